// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader.
//   - default widths and depth for the burst reader and its read-side FIFO
//   - FIFO read latency (rd_en in cycle t -> rd_ack/dout in cycle t+1)
//   - burst reader state encoding
package fifo_pkg;

   localparam int DEFAULT_DATA_W     = 32;
   localparam int DEFAULT_FIFO_DEPTH = 8;
   localparam int DEFAULT_CNT_W      = 4;

   // A read issued in cycle t is acknowledged in cycle t+1. The single
   // pend flag in the reader encodes exactly this one-cycle latency.
   localparam int FIFO_RD_LATENCY = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      RUN   = 3'b001,
      DRAIN = 3'b010,
      DONE  = 3'b011,
      ERR   = 3'b100
   } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order skid buffer between the FIFO read port and the
// downstream valid/ready stream.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   flush       - drop all buffered entries (occupancy -> 0)
//   push, din   - write one entry at the tail
//   pop         - remove the head entry
//   dout        - head entry (meaningful while occ != 0)
//   occ         - number of entries held, 0..2
// The caller never pushes into a full buffer unless it pops the same cycle.
module rd_skid_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        occ
);

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the data entries are reset as well (not only occ) because the
         // head entry drives m_data directly and must read zero out of reset.
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         occ <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word goes behind whatever
               // remains after the head leaves.
               if (occ == 2'd1) begin
                  head <= din;
               end else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout = head;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the 8-deep FIFO. Pops a host-requested burst
// of 1..FIFO_DEPTH words and presents them on a valid/ready stream.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   start, len              - one-cycle burst request and its length (IDLE only)
//   err_clr                 - leave ERR and return to IDLE
//   fifo_empty              - FIFO empty flag
//   fifo_rd_en              - FIFO read request (combinational)
//   fifo_rd_ack, fifo_dout  - read acknowledge and data, one cycle after rd_en
//   fifo_rd_err             - FIFO read-error flag
//   m_valid, m_data, m_ready - downstream stream
//   busy                    - burst in progress (RUN or DRAIN)
//   done                    - one-cycle pulse at burst completion
//   err                     - high while in ERR
//   words_out               - words delivered in the current or last burst
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              err_clr,
   input  logic              fifo_empty,
   input  logic              fifo_rd_ack,
   input  logic              fifo_rd_err,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  words_out
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(FIFO_DEPTH);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] rem;
   logic             pend;
   logic [1:0]       occ;
   logic [2:0]       occ_after;
   logic [2:0]       occ_next;
   logic             push;
   logic             pop;
   logic             err_evt;
   logic             enter_err;
   logic             start_ok;

   assign start_ok = start && (len != '0) && (len <= MAX_LEN);

   // A read outstanding from last cycle must come back acknowledged and
   // error-free; otherwise the word is discarded and the block faults.
   assign err_evt   = pend && (!fifo_rd_ack || fifo_rd_err);
   assign push      = pend && fifo_rd_ack && !fifo_rd_err;
   assign m_valid   = (occ != 2'd0);
   assign pop       = m_valid && m_ready;
   assign enter_err = (state_next == ERR) && (state != ERR);

   // Slots committed once this cycle settles: held words plus the word in
   // flight, minus the one leaving now. Issuing only while this is below 2
   // keeps the buffer from overflowing and still allows one read per cycle
   // when the consumer is always ready.
   assign occ_after = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
   assign occ_next  = {1'b0, occ} + {2'b00, push} - {2'b00, pop};

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_next unassigned, which would infer a latch.
      state_next = state;
      unique case (state)
         IDLE:  if (start_ok) state_next = RUN;
         RUN: begin
            if (err_evt)                                state_next = ERR;
            else if (fifo_rd_en && rem == CNT_W'(1))    state_next = DRAIN;
         end
         DRAIN: begin
            if (err_evt)                                state_next = ERR;
            else if (!pend && occ_next == 3'd0)         state_next = DONE;
         end
         DONE:  state_next = IDLE;
         ERR:   if (err_clr) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      fifo_rd_en = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      unique case (state)
         RUN: begin
            busy       = 1'b1;
            fifo_rd_en = (rem != '0) && !fifo_empty && (occ_after < 3'd2);
         end
         DRAIN: busy = 1'b1;
         DONE:  done = 1'b1;
         ERR:   err  = 1'b1;
         default: ;
      endcase
   end

   // Burst bookkeeping: remaining reads, read in flight, delivered count.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem       <= '0;
         pend      <= 1'b0;
         words_out <= '0;
      end else begin
         if (state == IDLE && start_ok) rem <= len;
         else if (fifo_rd_en)            rem <= rem - CNT_W'(1);

         // A read issued in the same cycle the fault is seen is abandoned.
         pend <= enter_err ? 1'b0 : fifo_rd_en;

         if (state == IDLE && start_ok) words_out <= '0;
         else if (pop)                   words_out <= words_out + CNT_W'(1);
      end
   end

   rd_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .flush (enter_err),
      .push  (push),
      .pop   (pop),
      .din   (fifo_dout),
      .dout  (m_data),
      .occ   (occ)
   );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed testbench for fifo_burst_reader. A small FIFO model answers each
// read one cycle later from a queue; expected outputs are hand-derived per
// cycle. Inputs change 1 time unit after the rising edge, outputs are
// compared 2 time units after it.
module tb_fifo_burst_reader;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] len = '0;
   logic          err_clr = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          ack_q = 1'b0;
   logic          force_nak = 1'b0;
   logic          fifo_rd_ack;
   logic          fifo_rd_err = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b0;
   logic          busy;
   logic          done;
   logic          err;
   logic [CW-1:0] words_out;

   logic [DW-1:0] q[$];
   int            n_vec = 0;
   int            n_bad = 0;

   assign fifo_rd_ack = ack_q && !force_nak;

   always #5 clk = ~clk;

   fifo_burst_reader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .len         (len),
      .err_clr     (err_clr),
      .fifo_empty  (fifo_empty),
      .fifo_rd_ack (fifo_rd_ack),
      .fifo_rd_err (fifo_rd_err),
      .fifo_dout   (fifo_dout),
      .fifo_rd_en  (fifo_rd_en),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .words_out   (words_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fifo_push(input logic [DW-1:0] d);
      q.push_back(d);
      fifo_empty = 1'b0;
   endtask

   task automatic fifo_clear();
      q.delete();
      fifo_empty = 1'b1;
   endtask

   // Advance one cycle; the FIFO model answers the read seen before the edge.
   task automatic tick();
      logic iss;
      iss = fifo_rd_en;
      @(posedge clk);
      #1;
      if (iss && q.size() != 0) begin
         ack_q     = 1'b1;
         fifo_dout = q.pop_front();
      end else begin
         ack_q = 1'b0;
      end
      fifo_empty = (q.size() == 0);
   endtask

   task automatic launch(input logic [CW-1:0] l, input logic rdy);
      tick();
      start   = 1'b1;
      len     = l;
      m_ready = rdy;
      #1;
   endtask

   // One directed cycle: drive ready (and optionally a FIFO write), then
   // compare rd_en, valid, data (when valid), done and busy.
   task automatic cyc(input string tag, input logic rdy, input int wr,
                      input logic e_rd, input logic e_v, input logic [DW-1:0] e_d,
                      input logic e_done, input logic e_busy);
      tick();
      start   = 1'b0;
      m_ready = rdy;
      if (wr >= 0) fifo_push(DW'(wr));
      #1;
      check({tag, ".rd_en"}, 32'(fifo_rd_en), 32'(e_rd));
      check({tag, ".valid"}, 32'(m_valid), 32'(e_v));
      if (e_v) check({tag, ".data"}, m_data, e_d);
      check({tag, ".done"}, 32'(done), 32'(e_done));
      check({tag, ".busy"}, 32'(busy), 32'(e_busy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic got_done;
      int   nexp;

      // Reset values
      tick();
      tick();
      #1;
      check("rst.valid", 32'(m_valid), 32'd0);
      check("rst.data", m_data, 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.err", 32'(err), 32'd0);
      check("rst.words", 32'(words_out), 32'd0);
      check("rst.rd_en", 32'(fifo_rd_en), 32'd0);
      reset = 1'b0;

      // Basic burst of 4 at full rate
      fifo_push(32'h11); fifo_push(32'h22); fifo_push(32'h33); fifo_push(32'h44);
      launch(4, 1'b1);
      cyc("basic.c1", 1, -1, 1, 0, 32'h00, 0, 1);
      cyc("basic.c2", 1, -1, 1, 0, 32'h00, 0, 1);
      cyc("basic.c3", 1, -1, 1, 1, 32'h11, 0, 1);
      cyc("basic.c4", 1, -1, 1, 1, 32'h22, 0, 1);
      cyc("basic.c5", 1, -1, 0, 1, 32'h33, 0, 1);
      cyc("basic.c6", 1, -1, 0, 1, 32'h44, 0, 1);
      cyc("basic.c7", 1, -1, 0, 0, 32'h00, 1, 0);
      cyc("basic.c8", 1, -1, 0, 0, 32'h00, 0, 0);
      check("basic.words", 32'(words_out), 32'd4);

      // Backpressure: ready low for cycles 0..4
      fifo_push(32'h11); fifo_push(32'h22); fifo_push(32'h33);
      launch(3, 1'b0);
      cyc("bp.c1", 0, -1, 1, 0, 32'h00, 0, 1);
      cyc("bp.c2", 0, -1, 1, 0, 32'h00, 0, 1);
      cyc("bp.c3", 0, -1, 0, 1, 32'h11, 0, 1);
      cyc("bp.c4", 0, -1, 0, 1, 32'h11, 0, 1);
      cyc("bp.c5", 1, -1, 1, 1, 32'h11, 0, 1);
      cyc("bp.c6", 1, -1, 0, 1, 32'h22, 0, 1);
      cyc("bp.c7", 1, -1, 0, 1, 32'h33, 0, 1);
      cyc("bp.c8", 1, -1, 0, 0, 32'h00, 1, 0);
      check("bp.words", 32'(words_out), 32'd3);

      // Empty stall: second word arrives in cycle 5
      fifo_push(32'hA1);
      launch(2, 1'b1);
      cyc("emp.c1", 1, -1, 1, 0, 32'h00, 0, 1);
      cyc("emp.c2", 1, -1, 0, 0, 32'h00, 0, 1);
      cyc("emp.c3", 1, -1, 0, 1, 32'hA1, 0, 1);
      cyc("emp.c4", 1, -1, 0, 0, 32'h00, 0, 1);
      cyc("emp.c5", 1, 32'hB2, 1, 0, 32'h00, 0, 1);
      cyc("emp.c6", 1, -1, 0, 0, 32'h00, 0, 1);
      cyc("emp.c7", 1, -1, 0, 1, 32'hB2, 0, 1);
      cyc("emp.c8", 1, -1, 0, 0, 32'h00, 1, 0);
      check("emp.words", 32'(words_out), 32'd2);

      // Read error: first acknowledge withheld
      fifo_push(32'hC1); fifo_push(32'hC2);
      launch(2, 1'b1);
      cyc("err.c1", 1, -1, 1, 0, 32'h00, 0, 1);
      force_nak = 1'b1;
      cyc("err.c2", 1, -1, 1, 0, 32'h00, 0, 1);
      cyc("err.c3", 1, -1, 0, 0, 32'h00, 0, 0);
      force_nak = 1'b0;
      check("err.c3.err", 32'(err), 32'd1);
      tick();
      start = 1'b1;
      len   = 4'd1;
      #1;
      check("err.c4.err", 32'(err), 32'd1);
      tick();
      start   = 1'b0;
      err_clr = 1'b1;
      #1;
      check("err.c5.err", 32'(err), 32'd1);
      check("err.c5.busy", 32'(busy), 32'd0);
      tick();
      err_clr = 1'b0;
      #1;
      check("err.c6.err", 32'(err), 32'd0);
      check("err.c6.busy", 32'(busy), 32'd0);
      fifo_clear();

      // Illegal lengths, then start during an 8-word burst
      for (int i = 1; i <= 8; i++) fifo_push(DW'(i));
      fifo_push(32'h99);
      launch(0, 1'b1);
      tick();
      start = 1'b0;
      #1;
      check("ill0.busy", 32'(busy), 32'd0);
      check("ill0.rd_en", 32'(fifo_rd_en), 32'd0);
      launch(9, 1'b1);
      tick();
      start = 1'b0;
      #1;
      check("ill9.busy", 32'(busy), 32'd0);
      check("ill9.rd_en", 32'(fifo_rd_en), 32'd0);
      launch(8, 1'b1);
      got_done = 1'b0;
      nexp     = 0;
      for (int c = 1; c < 40 && !got_done; c++) begin
         tick();
         start = (c == 3);
         len   = 4'd3;
         #1;
         if (m_valid) begin
            check("b8.data", m_data, 32'(nexp + 1));
            nexp++;
         end
         if (done) got_done = 1'b1;
      end
      start = 1'b0;
      check("b8.done_seen", 32'(got_done), 32'd1);
      check("b8.count", 32'(nexp), 32'd8);
      check("b8.words", 32'(words_out), 32'd8);
      check("b8.fifo_left", 32'(q.size()), 32'd1);
      fifo_clear();

      // Reset with the buffer full mid-burst
      fifo_push(32'h71); fifo_push(32'h72); fifo_push(32'h73); fifo_push(32'h74);
      launch(4, 1'b0);
      cyc("rsm.c1", 0, -1, 1, 0, 32'h00, 0, 1);
      cyc("rsm.c2", 0, -1, 1, 0, 32'h00, 0, 1);
      cyc("rsm.c3", 0, -1, 0, 1, 32'h71, 0, 1);
      cyc("rsm.c4", 0, -1, 0, 1, 32'h71, 0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rsm.valid", 32'(m_valid), 32'd0);
      check("rsm.data", m_data, 32'd0);
      check("rsm.busy", 32'(busy), 32'd0);
      check("rsm.done", 32'(done), 32'd0);
      check("rsm.err", 32'(err), 32'd0);
      check("rsm.words", 32'(words_out), 32'd0);
      check("rsm.rd_en", 32'(fifo_rd_en), 32'd0);
      fifo_clear();
      fifo_push(32'h5A);
      launch(1, 1'b1);
      cyc("post.c1", 1, -1, 1, 0, 32'h00, 0, 1);
      cyc("post.c2", 1, -1, 0, 0, 32'h00, 0, 1);
      cyc("post.c3", 1, -1, 0, 1, 32'h5A, 0, 1);
      cyc("post.c4", 1, -1, 0, 0, 32'h00, 1, 0);
      check("post.words", 32'(words_out), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
